// File: rtl/daq_pkg.sv
// rtl/daq_pkg.sv - shared DAQ word width, type codes, abort marker and arbiter state encodings
package daq_pkg;

  localparam int DAQ_W = 32;

  localparam logic [7:0] DAQT_DRO_DATA = 8'd48;
  localparam logic [7:0] DAQT_ENC_DATA = 8'd49;
  localparam logic [7:0] DAQT_SAMPLE   = 8'd50;

  // Written as the last word of a packet whose source went silent mid-packet.
  localparam logic [DAQ_W-1:0] DAQ_ABORT_MARKER = 32'hFFFF_FFFF;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic             last;
    logic [DAQ_W-1:0] data;
  } daq_word_t;

endpackage

// File: rtl/daq_fifo.sv
// rtl/daq_fifo.sv - synchronous first-word-fall-through FIFO with occupancy output
module daq_fifo #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 33
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  output logic                     push_ready_o,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic                     valid_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic             full, do_push, do_pop;

  assign full         = (level_q == LW'(DEPTH));
  assign valid_o      = (level_q != '0);
  assign do_pop       = pop_i && valid_o;
  // A pop in the same cycle frees the slot, so a full FIFO can still take a push.
  assign push_ready_o = !full || do_pop;
  assign do_push      = push_i && push_ready_o;
  assign head_o       = mem_q[rd_ptr_q];
  assign level_o      = level_q;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/daq_arbiter.sv
// rtl/daq_arbiter.sv - round-robin packet arbiter for DAQ sources feeding one buffered upstream port
module daq_arbiter
  import daq_pkg::*;
#(
  parameter int NREQ           = 4,
  parameter int FIFO_DEPTH     = 64,
  parameter int MAX_PKT_WORDS  = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NREQ-1:0]               daq_req,
  output logic [NREQ-1:0]               daq_grant,
  input  logic [NREQ*DAQ_W-1:0]         daq_data,
  input  logic [NREQ-1:0]               daq_valid,
  input  logic [NREQ-1:0]               daq_end,
  output logic [DAQ_W-1:0]              out_data,
  output logic                          out_end,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  input  logic                          err_clear,
  output logic                          timeout_err,
  output logic                          overflow_err,
  output logic                          protocol_err
);

  localparam int IDXW     = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GATE_LVL = FIFO_DEPTH - MAX_PKT_WORDS - 1;
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES - 1);

  function automatic logic [IDXW-1:0] rr_pick(input logic [NREQ-1:0] req,
                                              input logic [IDXW-1:0] last);
    logic [IDXW-1:0] pick;
    logic            found;
    int              k;
    pick  = last;
    found = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      k = (int'(last) + i) % NREQ;
      if (!found && req[k[IDXW-1:0]]) begin
        pick  = k[IDXW-1:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [IDXW-1:0] idx);
    logic [NREQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  arb_state_e      state_q;
  logic [IDXW-1:0] sel_q, last_q;
  logic [NREQ-1:0] grant_q;
  logic [TW-1:0]   tmo_q;
  logic            pushed_q;
  logic            timeout_err_q, overflow_err_q, protocol_err_q;
  logic            timeout_err_d, overflow_err_d, protocol_err_d;

  logic            busy, sel_valid, sel_end, accept, stray, tmo_fire, free_ok;
  logic            push_req, push_ready, pop;
  logic [DAQ_W-1:0] sel_word;
  daq_word_t       push_word, head_word;

  always_comb begin
    sel_valid = 1'b0;
    sel_end   = 1'b0;
    sel_word  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (sel_q == IDXW'(i)) begin
        sel_valid = daq_valid[i];
        sel_end   = daq_end[i];
        sel_word  = daq_data[i*DAQ_W +: DAQ_W];
      end
    end
  end

  assign busy     = (state_q == ST_BUSY);
  assign accept   = busy && sel_valid;
  // Any strobe outside the granted source's packet window is a misbehaving source.
  assign stray    = busy ? ((daq_valid & ~onehot(sel_q)) != '0) : (daq_valid != '0);
  assign tmo_fire = busy && !sel_valid && (tmo_q == '0);
  assign free_ok  = int'(fifo_level) <= GATE_LVL;

  assign pop            = out_valid && out_ready;
  assign push_req       = accept || (tmo_fire && pushed_q);
  assign push_word.last = accept ? sel_end : 1'b1;
  assign push_word.data = accept ? sel_word : DAQ_ABORT_MARKER;

  assign timeout_err_d  = (timeout_err_q  && !err_clear) || tmo_fire;
  assign overflow_err_d = (overflow_err_q && !err_clear) || (push_req && !push_ready);
  assign protocol_err_d = (protocol_err_q && !err_clear) || stray;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      sel_q          <= '0;
      last_q         <= IDXW'(NREQ - 1);
      grant_q        <= '0;
      tmo_q          <= '0;
      pushed_q       <= 1'b0;
      timeout_err_q  <= 1'b0;
      overflow_err_q <= 1'b0;
      protocol_err_q <= 1'b0;
    end else begin
      grant_q        <= '0;
      timeout_err_q  <= timeout_err_d;
      overflow_err_q <= overflow_err_d;
      protocol_err_q <= protocol_err_d;
      case (state_q)
        ST_IDLE: begin
          // Sources cannot be stalled, so only grant with a whole packet of room.
          if ((daq_req != '0) && free_ok) begin
            sel_q    <= rr_pick(daq_req, last_q);
            grant_q  <= onehot(rr_pick(daq_req, last_q));
            state_q  <= ST_BUSY;
            tmo_q    <= TMO_LOAD;
            pushed_q <= 1'b0;
          end
        end
        ST_BUSY: begin
          if (accept) begin
            tmo_q <= TMO_LOAD;
            if (push_ready) pushed_q <= 1'b1;
            if (sel_end) begin
              last_q  <= sel_q;
              state_q <= ST_IDLE;
            end
          end else if (tmo_q == '0) begin
            last_q  <= sel_q;
            state_q <= ST_IDLE;
          end else begin
            tmo_q <= tmo_q - 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  daq_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(daq_word_t))
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push_i       (push_req),
    .push_data_i  (push_word),
    .push_ready_o (push_ready),
    .pop_i        (pop),
    .head_o       (head_word),
    .valid_o      (out_valid),
    .level_o      (fifo_level)
  );

  assign daq_grant    = grant_q;
  assign out_data     = head_word.data;
  assign out_end      = head_word.last;
  assign timeout_err  = timeout_err_q;
  assign overflow_err = overflow_err_q;
  assign protocol_err = protocol_err_q;

endmodule

// File: tb/tb_daq_arbiter.sv
// tb/tb_daq_arbiter.sv - directed self-checking bench for daq_arbiter
module tb_daq_arbiter;

  localparam int NREQ = 4;
  localparam int DEPTH = 8;

  logic          clk;
  logic          rst;
  logic [3:0]    daq_req;
  logic [3:0]    daq_grant;
  logic [127:0]  daq_data;
  logic [3:0]    daq_valid;
  logic [3:0]    daq_end;
  logic [31:0]   out_data;
  logic          out_end;
  logic          out_valid;
  logic          out_ready;
  logic [3:0]    fifo_level;
  logic          err_clear;
  logic          timeout_err;
  logic          overflow_err;
  logic          protocol_err;

  int tests = 0;
  int fails = 0;
  logic [32:0] out_q[$];
  logic [32:0] exp_q[$];
  int          grant_log[$];

  daq_arbiter #(
    .NREQ           (NREQ),
    .FIFO_DEPTH     (DEPTH),
    .MAX_PKT_WORDS  (4),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .daq_req      (daq_req),
    .daq_grant    (daq_grant),
    .daq_data     (daq_data),
    .daq_valid    (daq_valid),
    .daq_end      (daq_end),
    .out_data     (out_data),
    .out_end      (out_end),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .fifo_level   (fifo_level),
    .err_clear    (err_clear),
    .timeout_err  (timeout_err),
    .overflow_err (overflow_err),
    .protocol_err (protocol_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) out_q.push_back({out_end, out_data});
    if (!rst && daq_grant != 4'b0) begin
      for (int i = 0; i < NREQ; i++) if (daq_grant[i]) grant_log.push_back(i);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    daq_req = '0; daq_valid = '0; daq_end = '0; daq_data = '0; err_clear = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    out_q.delete(); exp_q.delete(); grant_log.delete();
  endtask

  task automatic wait_grant(output int idx, output int waited);
    idx = -1;
    waited = -1;
    for (int i = 0; i < 40; i++) begin
      if (daq_grant != 4'b0) begin
        for (int j = 0; j < NREQ; j++) if (daq_grant[j]) idx = j;
        waited = i;
        break;
      end
      step();
    end
  endtask

  task automatic send_pkt(input int src, input int n, input logic [31:0] base, input logic with_end);
    for (int k = 0; k < n; k++) begin
      daq_valid = 4'b0; daq_end = 4'b0;
      daq_valid[src] = 1'b1;
      daq_data[src*32 +: 32] = base + 32'(k);
      daq_end[src] = with_end && (k == n - 1);
      exp_q.push_back({daq_end[src], base + 32'(k)});
      step();
    end
    daq_valid = 4'b0; daq_end = 4'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100 && out_valid; i++) step();
  endtask

  task automatic check_out(input string tag);
    chk({tag, "_count"}, 64'(out_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("%s_word%0d", tag, i), (i < out_q.size()) ? 64'(out_q[i]) : 64'hDEAD, 64'(exp_q[i]));
  endtask

  int idx, waited;

  initial begin
    out_ready = 1'b0;
    do_reset();
    chk("rst_grant", 64'(daq_grant), 64'h0);
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_level", 64'(fifo_level), 64'h0);
    chk("rst_errs", 64'({timeout_err, overflow_err, protocol_err}), 64'h0);

    // Single packet from source 1, held in the FIFO to observe the level.
    daq_req = 4'b0010;
    step();
    chk("single_grant", 64'(daq_grant), 64'h2);
    daq_req = 4'b0;
    step();
    chk("single_grant_pulse", 64'(daq_grant), 64'h0);
    step();
    send_pkt(1, 3, 32'hA000_000A, 1'b1);
    chk("single_level", 64'(fifo_level), 64'h3);
    out_ready = 1'b1;
    wait_drain();
    check_out("single");
    chk("single_empty_level", 64'(fifo_level), 64'h0);

    // Round-robin order with three sources held high from reset.
    do_reset();
    out_ready = 1'b1;
    daq_req = 4'b1101;
    for (int p = 0; p < 4; p++) begin
      wait_grant(idx, waited);
      chk($sformatf("rr_grant%0d", p), 64'(idx), (p == 1) ? 64'd2 : (p == 2) ? 64'd3 : 64'd0);
      chk($sformatf("rr_latency%0d", p), 64'(waited), 64'd1);
      if (p == 3) daq_req = 4'b0;
      step();
      chk($sformatf("rr_pulse%0d", p), 64'(daq_grant), 64'h0);
      send_pkt((p == 1) ? 2 : (p == 2) ? 3 : 0, 3, 32'h100 * 32'(p), 1'b1);
    end
    wait_drain();
    check_out("rr");

    // Space gating: 8-deep FIFO holding 4 words leaves no room for another packet.
    do_reset();
    out_ready = 1'b0;
    daq_req = 4'b0001;
    wait_grant(idx, waited);
    chk("gate_first", 64'(idx), 64'd0);
    daq_req = 4'b0010;
    step();
    send_pkt(0, 4, 32'h0B00, 1'b1);
    repeat (10) step();
    chk("gate_held", 64'(grant_log.size()), 64'd1);
    chk("gate_level4", 64'(fifo_level), 64'h4);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("gate_level3", 64'(fifo_level), 64'h3);
    step();
    chk("gate_second", 64'(daq_grant), 64'h2);
    daq_req = 4'b0;
    step();
    send_pkt(1, 4, 32'h0C00, 1'b1);
    chk("gate_level7", 64'(fifo_level), 64'h7);
    out_ready = 1'b1;
    wait_drain();
    check_out("gate");
    chk("gate_no_ovf", 64'(overflow_err), 64'h0);

    // Timeout: source 2 sends one word and stalls; marker closes the packet.
    do_reset();
    out_ready = 1'b1;
    daq_req = 4'b1100;
    wait_grant(idx, waited);
    chk("tmo_first", 64'(idx), 64'd2);
    daq_req = 4'b1000;
    step();
    send_pkt(2, 1, 32'h0000_2222, 1'b0);
    exp_q.push_back({1'b1, 32'hFFFF_FFFF});
    chk("tmo_err_before", 64'(timeout_err), 64'h0);
    wait_grant(idx, waited);
    chk("tmo_next", 64'(idx), 64'd3);
    chk("tmo_err", 64'(timeout_err), 64'h1);
    daq_req = 4'b0;
    step();
    send_pkt(3, 1, 32'h0000_3333, 1'b1);
    wait_drain();
    check_out("tmo");
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    chk("tmo_cleared", 64'(timeout_err), 64'h0);

    // Stray strobe from source 2 while source 0 owns the path.
    do_reset();
    out_ready = 1'b1;
    daq_req = 4'b0001;
    wait_grant(idx, waited);
    chk("proto_grant", 64'(idx), 64'd0);
    daq_req = 4'b0;
    step();
    daq_valid = 4'b0101;
    daq_data[0 +: 32] = 32'h0D00;
    daq_data[64 +: 32] = 32'hBAD0_BAD0;
    exp_q.push_back({1'b0, 32'h0D00});
    step();
    daq_valid = 4'b0;
    chk("proto_err", 64'(protocol_err), 64'h1);
    send_pkt(0, 2, 32'h0D01, 1'b1);
    wait_drain();
    check_out("proto");

    // Reset in the middle of a packet.
    do_reset();
    out_ready = 1'b0;
    daq_req = 4'b0010;
    wait_grant(idx, waited);
    chk("mid_grant", 64'(idx), 64'd1);
    daq_req = 4'b0;
    step();
    send_pkt(1, 2, 32'h0E00, 1'b0);
    chk("mid_level2", 64'(fifo_level), 64'h2);
    rst = 1'b1;
    step();
    chk("mid_out_valid", 64'(out_valid), 64'h0);
    chk("mid_level0", 64'(fifo_level), 64'h0);
    chk("mid_grant_off", 64'(daq_grant), 64'h0);
    rst = 1'b0;
    grant_log.delete();
    repeat (10) step();
    chk("mid_no_grant", 64'(grant_log.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/daq_arbiter.md
Name: daq_arbiter

Overview:
- Shares the single DAQ upstream path between NREQ packet sources (DRO reader, encoder, other sampling blocks) using the req/grant/valid/end protocol those sources already drive.
- Grants one source at a time, round-robin, and holds the grant until that source's packet end.
- Buffers packet words in an internal FIFO that drains to the DAQ framer through a valid/ready port.
- Grants only when the FIFO has room for a full packet, because sources cannot be back-pressured.

Parameters:
- NREQ, 4, number of requesting sources
- FIFO_DEPTH, 64, words of 33 bits (data + end flag); power of two
- MAX_PKT_WORDS, 4, longest legal packet; the reservation is MAX_PKT_WORDS+1
- TIMEOUT_CYCLES, 1024, cycles without a word from the granted source before abort

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- daq_req  in  NREQ  per-source request
- daq_grant  out  NREQ  per-source grant, one-cycle pulse
- daq_data  in  NREQ*32  per-source word; source i occupies bits [32i+31:32i]
- daq_valid  in  NREQ  per-source word strobe
- daq_end  in  NREQ  per-source last-word flag, qualified by daq_valid
- out_data  out  32  FIFO head word
- out_end  out  1  head word is last of its packet
- out_valid  out  1  FIFO not empty
- out_ready  in  1  downstream accepts head word
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy
- err_clear  in  1  clears all sticky error flags
- timeout_err  out  1  sticky
- overflow_err  out  1  sticky
- protocol_err  out  1  sticky

Behaviour:
- Reset values:
  - daq_grant=0, out_valid=0, fifo_level=0, all error flags 0.
  - State IDLE; last-granted pointer = NREQ-1, so source 0 has priority first.
- State IDLE:
  - Arbitration fires when (daq_req != 0) and (FIFO_DEPTH - fifo_level >= MAX_PKT_WORDS+1).
  - The winner is the first requesting index after last, searching upward with wrap.
  - Next cycle: daq_grant[sel]=1 for exactly one cycle, state=BUSY, timeout counter loaded.
  - Latency: a request sampled in cycle N is granted in cycle N+1.
- State BUSY:
  - daq_valid[sel] pushes {daq_end[sel], daq_data[sel]} into the FIFO and reloads the timeout counter.
  - daq_valid[sel] && daq_end[sel]: last=sel; state=IDLE next cycle. The earliest next grant is 2 cycles after the end word.
  - daq_req from sel still high during the grant cycle is ignored. A request still high later in BUSY is ignored; it is re-arbitrated in IDLE.
  - daq_valid from any non-selected source, or any daq_valid in IDLE: word dropped, protocol_err=1.
  - More than MAX_PKT_WORDS words in one packet: extra words are still pushed while there is space. A push when the FIFO is full drops the word and sets overflow_err=1.
  - Timeout counter reaching 0 (no word for TIMEOUT_CYCLES cycles):
    - If at least one word of the packet was pushed, push marker 0xFFFFFFFF with end=1 so the packet is closed. Space for it is guaranteed by the reservation.
    - Set timeout_err=1, last=sel, state=IDLE.
- FIFO:
  - First-word fall-through: out_data/out_end valid whenever out_valid=1.
  - Pop on out_valid && out_ready.
  - Simultaneous push and pop keeps fifo_level unchanged and is legal when full.
  - Pointers wrap modulo FIFO_DEPTH.
- Errors: sticky until err_clear. If err_clear and a new error occur in the same cycle, the flag is set.
- Reset mid-packet: FIFO flushed, grant dropped, state=IDLE. Sources restart from their own reset.

Decomposition:
- Shared package daq_pkg holds:
  - DAQ word width (32)
  - packet type codes, e.g. DAQT_DRO_DATA=48
  - abort marker 0xFFFFFFFF
  - state encodings IDLE/BUSY
- One sub-module, daq_fifo: synchronous FWFT FIFO, 33 bits wide, FIFO_DEPTH deep, with a level output.
- The round-robin search stays inline as a function.

Test Plan:
- Single packet: req[1] in cycle 10 → grant[1] pulse in cycle 11; words A,B,C(end) in cycles 13–15 → out emits A,B,C with out_end only on C; fifo_level peaks at 3.
- Round-robin: req[0], req[2] and req[3] held high from reset, 3-word packets → grant order 0,2,3,0.
- Space gating, FIFO_DEPTH=8, MAX_PKT_WORDS=4, out_ready=0 → the first packet (4 words) is granted, the second is not (free 4 < 5); setting out_ready=1 until fifo_level ≤ 3 grants it.
- Timeout, TIMEOUT_CYCLES=16: granted source sends 1 word then stops → 0xFFFFFFFF with end=1 follows that word, timeout_err=1, next requester granted; err_clear → flag 0.
- Protocol error: daq_valid[2] pulsed while source 0 is granted → word absent from output, protocol_err=1, source 0's packet intact.
- Reset mid-packet: rst asserted after 2 of 3 words → out_valid=0 and fifo_level=0 next cycle, no grant until a new request.
